// File: rtl/udp_rx_buf_ctrl.sv
// Ping-pong frame buffer between the UDP rx parser and a frame consumer, driving an external simple dual-port RAM.
// Latency: RAM write 1 cycle after rx_word_valid_i; rd_valid_o 2 cycles after each ram_re_o (1 RAM + 1 output register).
// Backpressure: none toward the parser (frames with no free bank or too many words are dropped and counted); reads stream contiguously.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   rx_word_valid_i/rx_word_i, rx_frame_done_i, rx_frame_abort_i, rx_data_length_i   parser side
//   ram_we_o/ram_waddr_o/ram_wdata_o, ram_re_o/ram_raddr_o/ram_rdata_i                RAM side, address = {bank, word}
//   frame_avail_o/frame_len_o/frame_words_o, rd_start_i, rd_valid_o/rd_data_o/rd_last_o, rd_done_o   consumer side
//   drop_cnt_o               saturating count of dropped frames
module udp_rx_buf_ctrl #(
  parameter int AW        = 9,
  parameter int HDR_BYTES = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx_word_valid_i,
  input  logic [31:0]   rx_word_i,
  input  logic          rx_frame_done_i,
  input  logic          rx_frame_abort_i,
  input  logic [15:0]   rx_data_length_i,
  output logic          ram_we_o,
  output logic [AW:0]   ram_waddr_o,
  output logic [31:0]   ram_wdata_o,
  output logic          ram_re_o,
  output logic [AW:0]   ram_raddr_o,
  input  logic [31:0]   ram_rdata_i,
  output logic          frame_avail_o,
  output logic [15:0]   frame_len_o,
  output logic [AW:0]   frame_words_o,
  input  logic          rd_start_i,
  output logic          rd_valid_o,
  output logic [31:0]   rd_data_o,
  output logic          rd_last_o,
  output logic          rd_done_o,
  output logic [15:0]   drop_cnt_o
);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DRAIN} rstate_e;

  localparam logic [AW:0] DEPTH_W   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_W     = {{AW{1'b0}}, 1'b1};
  localparam logic [15:0] HDR_LEN16 = 16'(HDR_BYTES);

  // write side state
  wstate_e      wstate_q;
  logic         wb_q;
  logic [AW:0]  wcnt_q;
  logic [1:0]   full_q;
  logic [15:0]  len_q   [2];
  logic [AW:0]  words_q [2];
  logic [15:0]  drop_cnt_q;
  logic         done_prev_q;
  logic         ram_we_q;
  logic [AW:0]  ram_waddr_q;
  logic [31:0]  ram_wdata_q;

  // read side state
  rstate_e      rstate_q;
  logic         rb_q;
  logic [AW:0]  rcnt_q;
  logic         ram_re_q;
  logic [AW:0]  ram_raddr_q;
  logic         re_last_q;
  logic         re_p1_q;
  logic         last_p1_q;
  logic         rd_valid_q;
  logic [31:0]  rd_data_q;
  logic         rd_last_q;
  logic         rd_done_q;

  logic         done_rise_d;
  logic         overflow_d;
  logic         commit_d;
  logic         release_d;
  logic [AW:0]  wcnt_inc_d;
  logic [15:0]  drop_inc_d;

  // done_prev_q resets high so a done level already asserted out of reset is not an edge
  assign done_rise_d = rx_frame_done_i & ~done_prev_q;
  assign wcnt_inc_d  = wcnt_q + ONE_W;
  assign drop_inc_d  = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;

  // a word arriving with the bank already holding 2^AW words cannot be stored
  assign overflow_d = (wstate_q == W_FILL) & rx_word_valid_i & (wcnt_q == DEPTH_W);

  // abort wins over done; an overflowing word kills the frame even with done in the same cycle
  assign commit_d  = (wstate_q == W_FILL) & done_rise_d & ~rx_frame_abort_i & ~overflow_d;
  assign release_d = (rstate_q == R_DRAIN) & rd_last_q;

  // write FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wstate_q    <= W_IDLE;
      wb_q        <= 1'b0;
      wcnt_q      <= '0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      words_q[0]  <= '0;
      words_q[1]  <= '0;
      drop_cnt_q  <= '0;
      done_prev_q <= 1'b1;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
    end else begin
      done_prev_q <= rx_frame_done_i;
      ram_we_q    <= 1'b0;

      if (commit_d) begin
        len_q[wb_q]   <= rx_data_length_i - HDR_LEN16;
        // a word in the same cycle as done is part of the frame
        words_q[wb_q] <= rx_word_valid_i ? wcnt_inc_d : wcnt_q;
        wb_q          <= ~wb_q;
      end

      case (wstate_q)
        W_IDLE: begin
          if (rx_word_valid_i) begin
            if (!full_q[wb_q]) begin
              ram_we_q    <= 1'b1;
              ram_waddr_q <= {wb_q, {AW{1'b0}}};
              ram_wdata_q <= rx_word_i;
              wcnt_q      <= ONE_W;
              wstate_q    <= W_FILL;
            end else begin
              drop_cnt_q <= drop_inc_d;
              wstate_q   <= W_DROP;
            end
          end
        end
        W_FILL: begin
          if (rx_frame_abort_i) begin
            wcnt_q   <= '0;
            wstate_q <= W_IDLE;
          end else if (overflow_d) begin
            drop_cnt_q <= drop_inc_d;
            wcnt_q     <= '0;
            wstate_q   <= done_rise_d ? W_IDLE : W_DROP;
          end else begin
            if (rx_word_valid_i) begin
              ram_we_q    <= 1'b1;
              ram_waddr_q <= {wb_q, wcnt_q[AW-1:0]};
              ram_wdata_q <= rx_word_i;
              wcnt_q      <= wcnt_inc_d;
            end
            if (done_rise_d) begin
              wcnt_q   <= '0;
              wstate_q <= W_IDLE;
            end
          end
        end
        W_DROP: begin
          if (done_rise_d || rx_frame_abort_i) begin
            wcnt_q   <= '0;
            wstate_q <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // bank occupancy: commit and release always target different banks
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 2'b00;
    end else begin
      if (commit_d)  full_q[wb_q] <= 1'b1;
      if (release_d) full_q[rb_q] <= 1'b0;
    end
  end

  // read FSM plus the 2-stage return pipeline (RAM latency, then output register)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rstate_q    <= R_IDLE;
      rb_q        <= 1'b0;
      rcnt_q      <= '0;
      ram_re_q    <= 1'b0;
      ram_raddr_q <= '0;
      re_last_q   <= 1'b0;
      re_p1_q     <= 1'b0;
      last_p1_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      ram_re_q   <= 1'b0;
      re_last_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      re_p1_q    <= ram_re_q;
      last_p1_q  <= re_last_q;
      rd_valid_q <= re_p1_q;
      rd_last_q  <= last_p1_q;
      if (re_p1_q) rd_data_q <= ram_rdata_i;

      case (rstate_q)
        R_IDLE: begin
          if (rd_start_i && full_q[rb_q]) begin
            rcnt_q   <= '0;
            rstate_q <= R_READ;
          end
        end
        R_READ: begin
          ram_re_q    <= 1'b1;
          ram_raddr_q <= {rb_q, rcnt_q[AW-1:0]};
          rcnt_q      <= rcnt_q + ONE_W;
          if (rcnt_q == words_q[rb_q] - ONE_W) begin
            re_last_q <= 1'b1;
            rstate_q  <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          if (release_d) begin
            rd_done_q <= 1'b1;
            rb_q      <= ~rb_q;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign ram_we_o      = ram_we_q;
  assign ram_waddr_o   = ram_waddr_q;
  assign ram_wdata_o   = ram_wdata_q;
  assign ram_re_o      = ram_re_q;
  assign ram_raddr_o   = ram_raddr_q;
  assign frame_avail_o = full_q[rb_q];
  assign frame_len_o   = len_q[rb_q];
  assign frame_words_o = words_q[rb_q];
  assign rd_valid_o    = rd_valid_q;
  assign rd_data_o     = rd_data_q;
  assign rd_last_o     = rd_last_q;
  assign rd_done_o     = rd_done_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: doc/udp_rx_buf_ctrl.md
Name: udp_rx_buf_ctrl

Overview:
Ping-pong buffer controller between the UDP receive parser and the user-side consumer. Takes the parser's 32-bit payload word stream and end-of-frame strobe, and writes each frame into one of two banks of an external simple dual-port RAM. It commits completed frames with their length and sequences full-frame reads to the consumer. Frames arriving with no free bank, or overflowing a bank, are dropped and counted.

Parameters:
AW, 9, word address width per bank; bank depth = 2^AW words
HDR_BYTES, 8, UDP header bytes subtracted from rx_data_length to get payload bytes

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_word_valid  in  1  one-cycle strobe, rx_word holds a payload word
rx_word  in  32  payload word, first byte in [31:24]
rx_frame_done  in  1  end-of-frame flag from the parser; level or sticky, rising edge detected internally
rx_frame_abort  in  1  one-cycle pulse, parser lost rxdv mid-frame
rx_data_length  in  16  UDP length field, stable while rx_frame_done is high
ram_we  out  1  RAM write enable
ram_waddr  out  AW+1  {bank, word address}
ram_wdata  out  32  RAM write data
ram_re  out  1  RAM read enable; RAM read latency is 1 cycle
ram_raddr  out  AW+1  {bank, word address}
ram_rdata  in  32  RAM read data
frame_avail  out  1  committed frame waiting in the read bank
frame_len  out  16  payload bytes of that frame
frame_words  out  AW+1  words stored for that frame
rd_start  in  1  consumer pulse, begin streaming the available frame
rd_valid  out  1  rd_data valid
rd_data  out  32  registered copy of ram_rdata
rd_last  out  1  with rd_valid, final word of the frame
rd_done  out  1  one-cycle pulse, bank released
drop_cnt  out  16  dropped frames, saturating at 16'hFFFF

Behaviour:
- Reset: both banks empty; wb=rb=0; all outputs 0; write FSM in W_IDLE; read FSM in R_IDLE; edge detector primed so a sticky rx_frame_done high at reset does not commit.
- done_rise = rx_frame_done & ~rx_frame_done_d (registered).
- Write FSM:
  - W_IDLE: a done_rise here is ignored, so zero-word frames are never committed. On rx_word_valid:
    - If full[wb]=0: write the word at {wb,0}, set wcnt=1, go to W_FILL.
    - Else: drop_cnt+1, go to W_DROP.
  - W_FILL: each rx_word_valid writes at {wb,wcnt} and increments wcnt.
    - If a word arrives with wcnt=2^AW: no write; drop_cnt+1; go to W_DROP; the bank stays uncommitted.
    - On done_rise: commit the bank. Set full[wb]=1, len[wb]=rx_data_length-HDR_BYTES (mod 2^16), words[wb]=wcnt; toggle wb; go to W_IDLE.
    - If rx_word_valid and done_rise occur in the same cycle, the word is written and counted first, then the bank is committed.
    - rx_frame_abort discards the frame: no commit, wcnt=0, go to W_IDLE.
  - W_DROP: all words are ignored. done_rise or rx_frame_abort returns to W_IDLE.
  - ram_we, ram_waddr and ram_wdata are registered, 1 cycle after rx_word_valid.
- Read FSM:
  - frame_avail=full[rb]; frame_len=len[rb]; frame_words=words[rb].
  - R_IDLE: rd_start with frame_avail=1 sets rcnt=0 and goes to R_READ. rd_start with frame_avail=0 is ignored.
  - R_READ: issue ram_re at {rb,rcnt} once per cycle, contiguously, with no backpressure. After issuing address words-1, go to R_DRAIN.
  - rd_valid/rd_data follow ram_re by 2 cycles (1 cycle RAM latency + 1 output register). rd_last accompanies the last word.
  - R_DRAIN: once the last rd_valid has been output, pulse rd_done, set full[rb]=0, toggle rb, go to R_IDLE. The next rd_start is accepted from the cycle after rd_done.
- Commit (full[wb] set) and release (full[rb] cleared) may occur in the same cycle. They always target different banks and both take effect.
- Write into a bank being read is impossible, because W_IDLE checks full[wb].
- Reset mid-frame or mid-read returns to the reset state immediately. Partially written data is abandoned.

Test Plan:
- Single frame: rx_data_length=20, 3 words then done -> frame_avail=1, frame_len=12, frame_words=3. After rd_start: 3 rd_valid cycles with the words in order, rd_last on the 3rd, then rd_done; frame_avail=0.
- Ping-pong: two frames (2 and 5 words) with no reads -> both committed. Reads return bank 0 then bank 1. A third frame arriving while both banks are full -> drop_cnt=1, nothing written.
- Abort: 4 words then rx_frame_abort, then a 1-word frame with done -> the latter is committed in bank 0 with frame_words=1.
- Overflow with AW=2: 5 words then done -> drop_cnt=1, frame_avail=0, wb unchanged.
- Sticky done: rx_frame_done held high after commit, then a new frame's words arrive -> no commit until done falls and rises again. Same-cycle last word + done_rise is counted.
- Concurrency: commit bank 1 in the same cycle bank 0's rd_done fires -> full={1,0}, frame_avail=1 for bank 1.
